// File: rtl/phoenix_pwm_generator.sv
// PWM generator with shadowed period/duty; optional duty fade enabled by PHOENIX_PWM_FADE_EN.
// Latency: pwm_out is registered, 1 clk behind the counter; period_start/active_duty change on the boundary edge.
// Backpressure: none; pwm_cycle/pwm_duty are sampled only at period boundaries and on IDLE->RUN.
module phoenix_pwm_generator #(
  parameter int PWM_COUNTER_BITS = 32,
  parameter int FADE_STEP        = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PWM_COUNTER_BITS-1:0] pwm_cycle,
  input  logic [PWM_COUNTER_BITS-1:0] pwm_duty,
  input  logic                        enable,
  output logic                        pwm_out,
  output logic                        period_start,
  output logic [PWM_COUNTER_BITS-1:0] active_duty
);

  localparam int W = PWM_COUNTER_BITS;
  localparam logic [W-1:0] ONE    = W'(1);
  localparam logic [W-1:0] STEP_W = W'(FADE_STEP);

`ifdef PHOENIX_PWM_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  // Initialisers match the reset values so an un-reset power-up is identical.
  state_t       state_q   = IDLE;
  logic [W-1:0] counter_q = '0;
  logic [W-1:0] cycle_q   = '0;
  logic [W-1:0] duty_q    = '0;
  logic         pwm_q     = 1'b0;
  logic         ps_q      = 1'b0;

  state_t       state_d;
  logic [W-1:0] counter_d;
  logic [W-1:0] cycle_d;
  logic [W-1:0] duty_d;
  logic         pwm_d;
  logic         ps_d;

  logic [W-1:0] fade_duty;
  logic [W-1:0] start_duty;
  logic [W-1:0] reload_duty;
  logic         last_count;

  // Fade target: step shadow duty toward pwm_duty by at most STEP_W, clamped so it never overshoots.
  always_comb begin
    fade_duty = pwm_duty;
    if (pwm_duty > duty_q) begin
      if ((pwm_duty - duty_q) > STEP_W) fade_duty = duty_q + STEP_W;
    end else begin
      if ((duty_q - pwm_duty) > STEP_W) fade_duty = duty_q - STEP_W;
    end
  end

  // With fade the duty ramps from 0 on start-up; without fade it tracks pwm_duty directly.
  assign start_duty  = FADE_EN ? '0        : pwm_duty;
  assign reload_duty = FADE_EN ? fade_duty : pwm_duty;
  assign last_count  = (counter_q == (cycle_q - ONE));

  // Next-state, counter, shadow and output logic.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    cycle_d   = cycle_q;
    duty_d    = duty_q;
    ps_d      = 1'b0;
    // Dropping enable blanks the pin on the very edge the FSM leaves RUN.
    pwm_d     = (state_q == RUN) && enable && (counter_q < duty_q);

    case (state_q)
      IDLE: begin
        counter_d = '0;
        cycle_d   = '0;
        duty_d    = '0;
        if (enable && (pwm_cycle != '0)) begin
          state_d = RUN;
          cycle_d = pwm_cycle;
          duty_d  = start_duty;
          ps_d    = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d   = IDLE;
          counter_d = '0;
          cycle_d   = '0;
          duty_d    = '0;
        end else if (last_count) begin
          counter_d = '0;
          if (pwm_cycle == '0) begin
            state_d = IDLE;
            cycle_d = '0;
            duty_d  = '0;
          end else begin
            cycle_d = pwm_cycle;
            duty_d  = reload_duty;
            ps_d    = 1'b1;
          end
        end else begin
          counter_d = counter_q + ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
        cycle_d   = '0;
        duty_d    = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      cycle_q   <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      cycle_q   <= cycle_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign active_duty  = duty_q;

endmodule

// File: tb/tb_phoenix_pwm_generator.sv
// Directed bench for phoenix_pwm_generator (default build, fade disabled).
// Expected pwm_out/period_start patterns are hand-derived per clock, one character per cycle.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_phoenix_pwm_generator;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pwm_cycle;
  logic [W-1:0] pwm_duty;
  logic         enable;
  logic         pwm_out;
  logic         period_start;
  logic [W-1:0] active_duty;

  int n_cmp = 0;
  int n_mis = 0;

  phoenix_pwm_generator #(.PWM_COUNTER_BITS(W), .FADE_STEP(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_cycle    (pwm_cycle),
    .pwm_duty     (pwm_duty),
    .enable       (enable),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .active_duty  (active_duty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One tick per character; ps/po give expected period_start/pwm_out, ad the active_duty throughout.
  task automatic run(input string tag, input string ps, input string po, input logic [W-1:0] ad);
    for (int i = 0; i < ps.len(); i++) begin
      tick();
      chk($sformatf("%s[%0d].ps", tag, i), {31'd0, period_start}, {31'd0, ps[i] == "1"});
      chk($sformatf("%s[%0d].po", tag, i), {31'd0, pwm_out},      {31'd0, po[i] == "1"});
      chk($sformatf("%s[%0d].ad", tag, i), active_duty, ad);
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    pwm_cycle = '0;
    pwm_duty  = '0;
    #1;
    // Power-up values before any clock edge.
    chk("init.po", {31'd0, pwm_out}, 32'd0);
    chk("init.ps", {31'd0, period_start}, 32'd0);
    chk("init.ad", active_duty, 32'd0);

    run("reset", "00", "00", 32'd0);

    // cycle 4, duty 1: strobe every 4, single high clk one cycle after strobe.
    reset = 1'b0; enable = 1'b1; pwm_cycle = 32'd4; pwm_duty = 32'd1;
    run("basic", "10001000", "01000100", 32'd1);

    // Change duty to 3 at counter 1: current period unaffected.
    run("hold_a", "10", "01", 32'd1);
    pwm_duty = 32'd3;
    run("hold_b", "00", "00", 32'd1);
    run("hold_c", "100010", "011101", 32'd3);

    // duty above cycle -> constant high; then duty 0 -> constant low.
    pwm_cycle = 32'd5; pwm_duty = 32'd7;
    run("full_a", "00", "11", 32'd3);
    run("full_b", "1000010000", "0111111111", 32'd7);
    pwm_duty = 32'd0;
    run("zero", "1000010000", "1000000000", 32'd0);

    // Enable dropped at counter 2 of an 8-cycle period, then re-raised.
    pwm_cycle = 32'd8; pwm_duty = 32'd3;
    run("en_a", "100", "011", 32'd3);
    enable = 1'b0;
    run("en_off", "00", "00", 32'd0);
    enable = 1'b1;
    run("en_on", "10", "01", 32'd3);

    // Mid-period reset with enable held high, restart right after release.
    pwm_cycle = 32'd10; pwm_duty = 32'd5;
    run("rst_a", "000000", "110000", 32'd3);
    run("rst_b", "1000", "0111", 32'd5);
    reset = 1'b1;
    run("rst_on", "00", "00", 32'd0);
    reset = 1'b0;
    run("rst_off", "10", "01", 32'd5);

    // pwm_cycle 0: finish the period, then drop to IDLE and stay there.
    pwm_cycle = 32'd0;
    run("stop_a", "00000000", "11110000", 32'd5);
    run("stop_b", "000", "000", 32'd0);

    // cycle 1: strobe every clock, duty 1 keeps the pin high.
    pwm_cycle = 32'd1; pwm_duty = 32'd1;
    run("c1", "1111", "0111", 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/phoenix_pwm_generator.md
PHOENIX_PWM_GENERATOR -- requirements
Module: phoenix_pwm_generator

Interface
REQ-001 SHALL have parameter PWM_COUNTER_BITS, default 32: width of pwm_cycle, pwm_duty, counter and duty readback.
REQ-002 SHALL have parameter FADE_STEP, default 256: maximum change of active duty per period; used only when PHOENIX_PWM_FADE_EN is defined.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port pwm_cycle, input, PWM_COUNTER_BITS: requested period in clk cycles, driven by the LED controller.
REQ-006 SHALL have port pwm_duty, input, PWM_COUNTER_BITS: requested high time in clk cycles, driven by the LED controller.
REQ-007 SHALL have port enable, input, 1: run request.
REQ-008 SHALL have port pwm_out, output, 1: registered LED drive, active-high.
REQ-009 SHALL have port period_start, output, 1: one-cycle strobe, high in the cycle the counter is 0 at the start of each period.
REQ-010 SHALL have port active_duty, output, PWM_COUNTER_BITS: duty value currently in use (shadow).

Function
REQ-011 SHALL implement two states, IDLE and RUN.
REQ-012 IDLE: counter = 0, pwm_out = 0, period_start = 0; shadow cycle holds 0.
REQ-013 IDLE->RUN SHALL occur on the edge where enable=1 and pwm_cycle != 0: shadow cycle <= pwm_cycle, shadow duty loaded per REQ-020/REQ-021, counter <= 0, period_start <= 1.
REQ-014 RUN: counter SHALL increment by 1 each clk while counter < shadow_cycle-1.
REQ-015 At counter == shadow_cycle-1 with enable=1 and pwm_cycle != 0: SHALL reload both shadows, counter <= 0, period_start <= 1 (period boundary). Shadow cycle = 1 gives a strobe every clk.
REQ-016 At counter == shadow_cycle-1 with pwm_cycle == 0: SHALL go to IDLE and clear the shadow cycle.
REQ-017 enable=0 in RUN SHALL go to IDLE on that edge, mid-period included; pwm_out = 0 from the next cycle.
REQ-018 pwm_out SHALL be registered: pwm_out(t+1) = (state==RUN) and (counter(t) < shadow_duty(t)). This is a fixed 1-clk latency from counter to pin.
REQ-019 Input changes mid-period SHALL have no effect until the next period boundary, so the output is glitch-free.
REQ-020 duty >= cycle SHALL give constant high; duty = 0 SHALL give constant low. Compare is unsigned, full width, no wrap.
REQ-021 Without fade, shadow duty SHALL load pwm_duty directly at each boundary and on IDLE->RUN.
REQ-022 active_duty SHALL equal shadow duty at all times; it is 0 in IDLE.

Reset
REQ-023 reset=1 SHALL force on the next edge: state IDLE, counter 0, shadow cycle 0, shadow duty 0, pwm_out 0, period_start 0, active_duty 0.
REQ-024 reset SHALL take priority over enable and all period events, including a reset asserted mid-period.
REQ-025 Without reset, the initial register values SHALL equal the reset values.

Configuration
REQ-026 Macro PHOENIX_PWM_FADE_EN defined: on IDLE->RUN shadow duty SHALL load 0. At each boundary it SHALL move toward pwm_duty by min(FADE_STEP, |pwm_duty - shadow_duty|), never overshooting.
REQ-027 Macro PHOENIX_PWM_FADE_EN undefined: SHALL behave per REQ-021, and FADE_STEP SHALL be ignored.

Verification
REQ-028 Reset, then enable=1, cycle=4, duty=1 -> period_start every 4 clks; pwm_out pattern 1,0,0,0 starting 1 clk after period_start.
REQ-029 cycle=4, duty=1 running; set duty=3 at counter=1 -> current period keeps 1 high clk, next period 3 high clks.
REQ-030 cycle=5, duty=7 -> pwm_out constant 1; duty=0 -> pwm_out constant 0; period_start continues every 5 clks.
REQ-031 enable dropped at counter=2 (cycle=8) -> pwm_out 0 the next clk, active_duty 0; enable re-raised -> new period with counter 0 and period_start=1.
REQ-032 reset pulsed mid-period, cycle=10, duty=5 -> all outputs 0 the next clk; with enable held high, restart on the first edge after reset is released.
REQ-033 PHOENIX_PWM_FADE_EN, FADE_STEP=2, cycle=4, duty 0->5 -> active_duty 0,2,4,5,5 over successive periods.
